// File: rtl/wb_dma_ch_arb.sv
// wb_dma_ch_arb: priority channel arbiter holding a registered grant until done/abort.
// Define WB_DMA_ARB_RR_EN for round-robin tie-break; default is lowest-index-wins.
module wb_dma_ch_arb #(
  parameter int         CH_NO   = 8,
  parameter logic [1:0] PRI_SEL = 2'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CH_NO-1:0]   ch_req,
  input  logic [3*CH_NO-1:0] ch_pri,
  input  logic               pause,
  input  logic               de_done,
  output logic [CH_NO-1:0]   ch_gnt,
  output logic [4:0]         ch_sel,
  output logic               gnt_vld,
  output logic [2:0]         gnt_pri
);

  // state   | meaning
  // IDLE    | no grant; arbitrate each cycle unless paused
  // GRANT   | grant held stable until de_done or the granted request drops
  // RELEASE | one dead cycle with grant cleared, then back to IDLE
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t           state, state_nxt;
  logic [7:0]       lvl_oh;
  logic [2:0]       top_lvl;
  logic [CH_NO-1:0] cand;
  logic [CH_NO-1:0] win_oh;
  logic [4:0]       win_idx;
  logic [CH_NO-1:0] gnt_nxt;
  logic [4:0]       sel_nxt;
  logic             vld_nxt;
  logic [2:0]       pri_nxt;
  logic             gnt_req;

  function automatic logic [2:0] eff_lvl(input logic [2:0] p);
    case (PRI_SEL)
      2'd0:    eff_lvl = {2'b00, |p};
      2'd1:    eff_lvl = (p > 3'd3) ? 3'd3 : p;
      default: eff_lvl = p;
    endcase
  endfunction

  // Levels are gathered as a one-hot OR so the top level is a plain MSB decode.
  always_comb begin
    lvl_oh  = '0;
    top_lvl = '0;
    cand    = '0;
    for (int n = 0; n < CH_NO; n++)
      if (ch_req[n]) lvl_oh[eff_lvl(ch_pri[3*n +: 3])] = 1'b1;
    for (int l = 0; l < 8; l++)
      if (lvl_oh[l]) top_lvl = 3'(l);
    for (int n = 0; n < CH_NO; n++)
      cand[n] = ch_req[n] && (eff_lvl(ch_pri[3*n +: 3]) == top_lvl);
  end

`ifdef WB_DMA_ARB_RR_EN
  logic [4:0] rr_ptr;

  always_comb begin
    int  idx;
    logic found;
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= CH_NO; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= CH_NO) idx = idx - CH_NO;
      if (!found && cand[idx]) begin
        found       = 1'b1;
        win_oh[idx] = 1'b1;
        win_idx     = 5'(idx);
      end
    end
  end
`else
  // Descending scan: the last hit is the lowest-index candidate.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    for (int n = CH_NO - 1; n >= 0; n--) begin
      if (cand[n]) begin
        win_oh    = '0;
        win_oh[n] = 1'b1;
        win_idx   = 5'(n);
      end
    end
  end
`endif

  // ch_gnt is one-hot on ch_sel, so this is the granted channel's request.
  assign gnt_req = |(ch_req & ch_gnt);

  always_comb begin
    state_nxt = state;
    gnt_nxt   = ch_gnt;
    sel_nxt   = ch_sel;
    vld_nxt   = gnt_vld;
    pri_nxt   = gnt_pri;
    case (state)
      IDLE: begin
        if (|ch_req && !pause) begin
          state_nxt = GRANT;
          gnt_nxt   = win_oh;
          sel_nxt   = win_idx;
          pri_nxt   = top_lvl;
          vld_nxt   = 1'b1;
        end
      end
      GRANT: begin
        if (de_done || !gnt_req) begin
          state_nxt = RELEASE;
          gnt_nxt   = '0;
          vld_nxt   = 1'b0;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        vld_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ch_gnt  <= '0;
      ch_sel  <= '0;
      gnt_vld <= 1'b0;
      gnt_pri <= '0;
    end else begin
      state   <= state_nxt;
      ch_gnt  <= gnt_nxt;
      ch_sel  <= sel_nxt;
      gnt_vld <= vld_nxt;
      gnt_pri <= pri_nxt;
    end
  end

`ifdef WB_DMA_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rr_ptr <= 5'(CH_NO - 1);
    else if (state == IDLE && state_nxt == GRANT)
      rr_ptr <= win_idx;
  end
`endif

endmodule

// File: tb/tb_wb_dma_ch_arb.sv
// tb_wb_dma_ch_arb: directed checks of wb_dma_ch_arb with three 4-channel instances
// (PRI_SEL 2, 0 and 1) sharing request/pause/done/reset stimulus.
module tb_wb_dma_ch_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic        pause;
  logic        de_done;
  logic [11:0] pri_a, pri_b, pri_c;

  logic [3:0] gnt_a, gnt_b, gnt_c;
  logic [4:0] sel_a, sel_b, sel_c;
  logic       vld_a, vld_b, vld_c;
  logic [2:0] gp_a, gp_b, gp_c;

  int errs   = 0;
  int checks = 0;
  int exp_seq[4];

  wb_dma_ch_arb #(.CH_NO(4), .PRI_SEL(2'd2)) dut_a (
    .clk(clk), .rst(rst), .ch_req(req), .ch_pri(pri_a), .pause(pause), .de_done(de_done),
    .ch_gnt(gnt_a), .ch_sel(sel_a), .gnt_vld(vld_a), .gnt_pri(gp_a));

  wb_dma_ch_arb #(.CH_NO(4), .PRI_SEL(2'd0)) dut_b (
    .clk(clk), .rst(rst), .ch_req(req), .ch_pri(pri_b), .pause(pause), .de_done(de_done),
    .ch_gnt(gnt_b), .ch_sel(sel_b), .gnt_vld(vld_b), .gnt_pri(gp_b));

  wb_dma_ch_arb #(.CH_NO(4), .PRI_SEL(2'd1)) dut_c (
    .clk(clk), .rst(rst), .ch_req(req), .ch_pri(pri_c), .pause(pause), .de_done(de_done),
    .ch_gnt(gnt_c), .ch_sel(sel_c), .gnt_vld(vld_c), .gnt_pri(gp_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    req     = '0;
    pause   = 1'b0;
    de_done = 1'b0;
    pri_a   = '0;
    pri_b   = '0;
    pri_c   = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef WB_DMA_ARB_RR_EN
    exp_seq = '{0, 1, 2, 0};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    rst = 1'b1; req = '0; pause = 1'b0; de_done = 1'b0;
    pri_a = '0; pri_b = '0; pri_c = '0;

    // reset values, sampled while reset is held
    rst = 1'b0;
    req = 4'b1111;
    tick();
    check_val("rst_gnt", gnt_a, 0);
    check_val("rst_sel", sel_a, 0);
    check_val("rst_vld", vld_a, 0);
    check_val("rst_pri", gp_a, 0);

    // 1: highest level wins, done with simultaneous request drop, 2-cycle gap
    do_reset();
    pri_a = {3'd0, 3'd5, 3'd3, 3'd0};
    req   = 4'b0110;
    tick();
    check_val("t1_gnt", gnt_a, 4);
    check_val("t1_sel", sel_a, 2);
    check_val("t1_pri", gp_a, 5);
    check_val("t1_vld", vld_a, 1);
    de_done = 1'b1;
    req     = 4'b0010;
    tick();
    de_done = 1'b0;
    check_val("t1_rel_vld", vld_a, 0);
    check_val("t1_rel_gnt", gnt_a, 0);
    check_val("t1_rel_sel", sel_a, 2);
    tick();
    check_val("t1_dead_vld", vld_a, 0);
    tick();
    check_val("t1_gnt2", gnt_a, 2);
    check_val("t1_sel2", sel_a, 1);
    check_val("t1_pri2", gp_a, 3);

    // 2: PRI_SEL=0 level collapse and PRI_SEL=1 clipping tie
    do_reset();
    pri_b = {3'd6, 3'd0, 3'd0, 3'd0};
    pri_c = {3'd6, 3'd0, 3'd7, 3'd0};
    req   = 4'b1010;
    tick();
    check_val("t2_b_sel", sel_b, 3);
    check_val("t2_b_gnt", gnt_b, 8);
    check_val("t2_b_pri", gp_b, 1);
    check_val("t2_c_sel", sel_c, 1);
    check_val("t2_c_gnt", gnt_c, 2);
    check_val("t2_c_pri", gp_c, 3);

    // 3: equal-priority tie-break sequence across repeated grants
    do_reset();
    pri_a = {3'd0, 3'd2, 3'd2, 3'd2};
    req   = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val($sformatf("t3_sel%0d", i), sel_a, exp_seq[i]);
      check_val($sformatf("t3_vld%0d", i), vld_a, 1);
      de_done = 1'b1;
      tick();
      de_done = 1'b0;
      tick();
    end

    // 4: no pre-emption; abort by request drop, then higher channel granted
    do_reset();
    pri_a = {3'd6, 3'd2, 3'd0, 3'd0};
    req   = 4'b0100;
    tick();
    check_val("t4_sel", sel_a, 2);
    req = 4'b1100;
    tick();
    check_val("t4_hold_sel", sel_a, 2);
    check_val("t4_hold_vld", vld_a, 1);
    req = 4'b1000;
    tick();
    check_val("t4_rel_vld", vld_a, 0);
    tick();
    check_val("t4_dead_vld", vld_a, 0);
    tick();
    check_val("t4_sel3", sel_a, 3);
    check_val("t4_pri3", gp_a, 6);
    check_val("t4_gnt3", gnt_a, 8);

    // 5: pause blocks new grants
    do_reset();
    pause = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("t5_paused_vld%0d", i), vld_a, 0);
    end
    pause = 1'b0;
    tick();
    check_val("t5_vld", vld_a, 1);
    check_val("t5_sel", sel_a, 0);

    // 6: asynchronous reset mid-grant, then pointer restarts
    do_reset();
    req = 4'b0001;
    tick();
    check_val("t6_pre_vld", vld_a, 1);
    #2;
    rst = 1'b0;
    #1;
    check_val("t6_async_gnt", gnt_a, 0);
    check_val("t6_async_vld", vld_a, 0);
    check_val("t6_async_sel", sel_a, 0);
    tick();
    rst = 1'b1;
    req = 4'b0011;
    tick();
    check_val("t6_sel", sel_a, 0);
    check_val("t6_vld", vld_a, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
